// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command responder:
// opcodes, response codes and FSM state encodings.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_BUS_REQ  = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    function automatic logic accepts_byte(input logic [2:0] s);
        return (s == ST_IDLE) || (s == ST_GET_ADDR) || (s == ST_GET_DATA);
    endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Byte-stream command parser that turns 'W'/'R' commands into
// register bus transfers and answers with a single response byte.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_we,
    output logic                  bus_re,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy,
    output logic                  cmd_error
);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        is_wr;
    logic        in_hs;
    logic        cnt_last;

    assign input_axis_tready = accepts_byte(state);
    assign busy              = (state != ST_IDLE);
    assign in_hs             = input_axis_tvalid & input_axis_tready;
    assign cnt_last          = (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            is_wr              <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
            bus_we             <= 1'b0;
            bus_re             <= 1'b0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            cmd_error          <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_hs) begin
                        if (input_axis_tdata == OP_WRITE) begin
                            is_wr <= 1'b1;
                            state <= ST_GET_ADDR;
                        end else if (input_axis_tdata == OP_READ) begin
                            is_wr <= 1'b0;
                            state <= ST_GET_ADDR;
                        end else begin
                            output_axis_tdata  <= RSP_BAD;
                            output_axis_tvalid <= 1'b1;
                            cmd_error          <= 1'b1;
                            state              <= ST_RESP;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (in_hs) begin
                        bus_addr <= input_axis_tdata;
                        if (is_wr) begin
                            state <= ST_GET_DATA;
                        end else begin
                            bus_re <= 1'b1;
                            cnt    <= '0;
                            state  <= ST_BUS_REQ;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (in_hs) begin
                        bus_wdata <= input_axis_tdata;
                        bus_we    <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_BUS_REQ;
                    end
                end
                ST_BUS_REQ: begin
                    cnt <= cnt + 16'd1;
                    // ack is checked first so it wins over a same-cycle timeout
                    if (bus_ack) begin
                        bus_we             <= 1'b0;
                        bus_re             <= 1'b0;
                        output_axis_tdata  <= is_wr ? RSP_OK : bus_rdata;
                        output_axis_tvalid <= 1'b1;
                        state              <= ST_RESP;
                    end else if (cnt_last) begin
                        bus_we             <= 1'b0;
                        bus_re             <= 1'b0;
                        output_axis_tdata  <= RSP_ERR;
                        output_axis_tvalid <= 1'b1;
                        cmd_error          <= 1'b1;
                        state              <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (output_axis_tready) begin
                        output_axis_tvalid <= 1'b0;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: stimulus queues expected
// bus transfers and response bytes, monitors pop and compare.
module tb_uart_cmd_responder;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         len;
    } bus_item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_tdata = '0;
    logic       in_tvalid = 1'b0;
    logic       in_tready;
    logic [7:0] out_tdata;
    logic       out_tvalid;
    logic       out_tready = 1'b1;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = '0;
    logic       bus_ack = 1'b0;
    logic       busy;
    logic       cmd_error;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;

    logic [7:0] exp_q[$];
    bus_item_t  bus_q[$];

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .input_axis_tdata(in_tdata),
        .input_axis_tvalid(in_tvalid),
        .input_axis_tready(in_tready),
        .output_axis_tdata(out_tdata),
        .output_axis_tvalid(out_tvalid),
        .output_axis_tready(out_tready),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we(bus_we),
        .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .busy(busy),
        .cmd_error(cmd_error)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // response monitor: stability under backpressure + scoreboard pop
    logic       holding = 1'b0;
    logic [7:0] held_d = '0;
    always @(negedge clk) begin
        if (cmd_error === 1'b1) err_seen++;
        if (out_tvalid === 1'b1) begin
            if (holding) chk("resp_stable", out_tdata, held_d);
            if (out_tready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", out_tdata, 32'hFFFF_FFFF);
                end else begin
                    chk("resp_byte", out_tdata, exp_q.pop_front());
                end
                holding = 1'b0;
            end else begin
                holding = 1'b1;
                held_d  = out_tdata;
            end
        end else begin
            holding = 1'b0;
        end
    end

    // bus monitor: strobe kind, address/data, stability and length
    logic      active = 1'b0;
    int        s_len = 0;
    bus_item_t cur;
    always @(negedge clk) begin
        if ((bus_we | bus_re) === 1'b1) begin
            if (bus_we && bus_re) chk("strobe_both", 1, 0);
            if (!active) begin
                if (bus_q.size() == 0) begin
                    chk("strobe_unexpected", {bus_we, bus_re}, 0);
                    cur = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, len: 0};
                end else begin
                    cur = bus_q.pop_front();
                    chk("strobe_we", bus_we, cur.we);
                    chk("strobe_re", bus_re, !cur.we);
                end
                if (!cur.we) cur.wdata = bus_wdata;
                active = 1'b1;
                s_len  = 0;
            end
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_wdata", bus_wdata, cur.wdata);
            s_len++;
        end else if (active) begin
            chk("strobe_len", s_len, cur.len);
            active = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        in_tvalid = 1'b1;
        in_tdata  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        cyc();
        in_tvalid = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [7:0] a,
                            input logic [7:0] d, input int len);
        bus_item_t it;
        it = '{we: we, addr: a, wdata: d, len: len};
        bus_q.push_back(it);
    endtask

    task automatic ack(input logic [7:0] rd);
        bus_rdata = rd;
        bus_ack   = 1'b1;
        cyc();
        bus_ack   = 1'b0;
    endtask

    initial begin
        int e0;
        int bp_bad;

        repeat (2) cyc();
        @(negedge clk);
        chk("rst_tready", in_tready, 1);
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tdata", out_tdata, 0);
        chk("rst_strobe", {bus_we, bus_re}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cmd_error, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // write, ack in third strobe cycle
        push_bus(1'b1, 8'h10, 8'hA5, 3);
        exp_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        @(negedge clk);
        chk("wr_latency", bus_we, 1);
        cyc();
        cyc();
        ack(8'h00);
        repeat (3) cyc();

        // read, ack in first strobe cycle
        push_bus(1'b0, 8'h22, 8'h00, 1);
        exp_q.push_back(8'h5C);
        send_byte(8'h52);
        send_byte(8'h22);
        ack(8'h5C);
        @(negedge clk);
        chk("ack_latency", out_tvalid, 1);
        chk("rd_strobe_low", bus_re, 0);
        repeat (3) cyc();

        // unknown opcode
        e0 = err_seen;
        exp_q.push_back(8'h3F);
        send_byte(8'h00);
        repeat (4) cyc();
        chk("bad_err_pulse", err_seen, e0 + 1);

        // timeout with no ack
        e0 = err_seen;
        push_bus(1'b0, 8'h33, 8'h00, 8);
        exp_q.push_back(8'h45);
        send_byte(8'h52);
        send_byte(8'h33);
        repeat (12) cyc();
        chk("to_err_pulse", err_seen, e0 + 1);

        // ack in the cycle the counter expires
        e0 = err_seen;
        push_bus(1'b1, 8'h44, 8'h99, 8);
        exp_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h44);
        send_byte(8'h99);
        repeat (7) cyc();
        ack(8'h00);
        repeat (4) cyc();
        chk("to_ack_no_err", err_seen, e0);

        // backpressure with next command queued
        out_tready = 1'b0;
        push_bus(1'b1, 8'h55, 8'h66, 1);
        exp_q.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h55);
        send_byte(8'h66);
        ack(8'h00);
        in_tvalid = 1'b1;
        in_tdata  = 8'h52;
        bp_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_tready !== 1'b0 || out_tvalid !== 1'b1) bp_bad++;
            cyc();
        end
        chk("bp_hold", bp_bad, 0);
        out_tready = 1'b1;
        push_bus(1'b0, 8'h77, 8'h00, 1);
        exp_q.push_back(8'h3C);
        send_byte(8'h52);
        send_byte(8'h77);
        ack(8'h3C);
        repeat (3) cyc();

        // reset mid-request
        push_bus(1'b1, 8'h12, 8'h34, 2);
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_strobe", {bus_we, bus_re}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tvalid", out_tvalid, 0);
        chk("rst_mid_tready", in_tready, 1);
        cyc();
        push_bus(1'b0, 8'h01, 8'h00, 1);
        exp_q.push_back(8'hC3);
        send_byte(8'h52);
        send_byte(8'h01);
        ack(8'hC3);

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && bus_q.size() == 0 && !active) break;
            cyc();
        end
        chk("resp_q_drained", exp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, stream byte width (only 8 supported); ADDR_WIDTH, 8, bus address width (only 8 supported); TIMEOUT, 1000, bus-ack timeout in clk cycles (1..65535).
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 input_axis_tdata  input  DATA_WIDTH  command byte from UART receiver.
REQ-005 input_axis_tvalid  input  1  command byte valid.
REQ-006 input_axis_tready  output  1  block accepts command byte.
REQ-007 output_axis_tdata  output  DATA_WIDTH  response byte to UART transmitter.
REQ-008 output_axis_tvalid  output  1  response byte valid.
REQ-009 output_axis_tready  input  1  transmitter accepts response byte.
REQ-010 bus_addr  output  ADDR_WIDTH  register address.
REQ-011 bus_wdata  output  DATA_WIDTH  write data.
REQ-012 bus_we / bus_re  output  1 each  write / read request, level-held until ack or timeout.
REQ-013 bus_rdata  input  DATA_WIDTH  read data, valid in the bus_ack cycle.
REQ-014 bus_ack  input  1  single-cycle request completion.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 cmd_error  output  1  one-cycle pulse on unknown opcode or timeout.

Function
REQ-017 A byte SHALL transfer only in a cycle where tvalid and tready are both high; input_axis_tready SHALL be high only in IDLE, GET_ADDR, GET_DATA.
REQ-018 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, BUS_REQ, RESP.
REQ-019 IDLE: 0x57 ('W') -> GET_ADDR (write flag set); 0x52 ('R') -> GET_ADDR (write flag clear); any other byte -> RESP with response 0x3F ('?') and a cmd_error pulse.
REQ-020 GET_ADDR: byte latched into bus_addr; write -> GET_DATA, read -> BUS_REQ.
REQ-021 GET_DATA: byte latched into bus_wdata -> BUS_REQ.
REQ-022 BUS_REQ: bus_we or bus_re (exactly one) SHALL be high from the cycle after entry until the cycle bus_ack is sampled high; bus_addr and bus_wdata SHALL be stable throughout.
REQ-023 On bus_ack the response SHALL be 0x4B ('K') for a write or bus_rdata for a read, and the FSM SHALL go to RESP; the strobe SHALL be low in the following cycle.
REQ-024 A 16-bit counter SHALL count BUS_REQ cycles; when it reaches TIMEOUT without ack, the strobe SHALL drop, the response SHALL be 0x45 ('E'), cmd_error SHALL pulse, and the FSM SHALL go to RESP.
REQ-025 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win.
REQ-026 bus_ack outside BUS_REQ SHALL be ignored.
REQ-027 RESP: output_axis_tvalid SHALL be high with tdata stable until tready is sampled high, then go low and the FSM SHALL return to IDLE; the minimum RESP occupancy is 1 cycle.
REQ-028 Input bytes arriving during BUS_REQ/RESP SHALL be back-pressured, never dropped.
REQ-029 Latency: last command byte accepted -> strobe high is 1 cycle; ack -> output_axis_tvalid high is 1 cycle.

Reset
REQ-030 rst SHALL force IDLE and clear the counter; all outputs SHALL be 0 after the reset edge, except input_axis_tready, which SHALL be 1.
REQ-031 rst mid-command or mid-request SHALL discard the partial command and drop any strobe or pending response at the same edge.

Structure
REQ-032 Opcode constants (0x57, 0x52) and response codes (0x4B, 0x3F, 0x45) plus the FSM state encodings SHALL live in a shared package uart_cmd_pkg.
REQ-033 Single flat module; no sub-modules. It SHALL connect directly to the uart wrapper's stream ports.

Verification
REQ-034 Write: bytes 0x57,0x10,0xA5; ack 3 cycles later -> bus_we with addr 0x10 / wdata 0xA5 held 3 cycles; response 0x4B.
REQ-035 Read: 0x52,0x22; ack with bus_rdata 0x5C -> bus_re seen, response 0x5C.
REQ-036 Bad opcode 0x00 -> cmd_error pulse, response 0x3F, no bus strobe.
REQ-037 Timeout: TIMEOUT=8, no ack -> strobe high exactly 8 cycles, response 0x45, cmd_error pulse; ack on cycle 8 -> 0x4B instead.
REQ-038 Backpressure: hold output_axis_tready low for 20 cycles with the next command queued -> tdata stable, input_axis_tready low, no bytes lost.
REQ-039 rst asserted during BUS_REQ -> strobe low after the edge, busy 0, next command 0x52,0x01 processed normally.
